// File: rtl/ahb_aes_slave_if.sv
// AHB-Lite bus bundle between the RISC-V master wrapper and the AES slave.
interface ahb_aes_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_aes_slave.sv
// AHB-Lite register slave for the AES-128 core: KEY/PT/CT/CTRL/STATUS,
// start pulse generation, ciphertext capture, CT-read wait states and
// two-cycle ERROR responses.
module ahb_aes_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WAIT_MAX   = 64
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahb_aes_slave_if.slave bus,
    output logic [127:0]   aes_key,
    output logic [127:0]   aes_pt,
    output logic           aes_start,
    input  logic [127:0]   aes_ct,
    input  logic           aes_done,
    output logic           irq
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam int unsigned   CW        = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    state_t state, next_state, addr_target;

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            a_off;
    logic [3:0]            off_q;
    logic                  wr_q;
    logic [CW-1:0]         wait_cnt;

    logic [31:0] key [4];
    logic [31:0] pt  [4];
    logic [31:0] ct  [4];
    logic        irq_en, busy, done, overrun, start_q, irq_q;

    logic        accept, hready_out, hresp, done_hit;
    logic        wr_en, ctrl_wr, status_wr, start_req, start_fire, overrun_set, busy_d;
    logic [31:0] rdata;
    logic        unused_bits;

    assign addr  = bus.HADDR;
    assign wdata = bus.HWDATA;
    assign a_off = addr[5:2];

    assign unused_bits = &{1'b0, addr[ADDR_WIDTH-1:6], addr[1:0], bus.HSIZE, bus.HTRANS[0]};

    assign hready_out = (state != ST_WAIT) && (state != ST_ERR1);
    assign accept     = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hready_out;
    assign done_hit   = aes_done & busy;

    assign wr_en       = (state == ST_DATA) & wr_q;
    assign ctrl_wr     = wr_en & (off_q == 4'h0);
    assign status_wr   = wr_en & (off_q == 4'h1);
    assign start_req   = ctrl_wr & wdata[0];
    assign start_fire  = start_req & ~busy;
    assign overrun_set = start_req & busy;

    // Error/wait decisions are taken in the address phase but must reflect
    // BUSY as it will be in the data phase, so they use BUSY's next value.
    assign busy_d = start_fire | (busy & ~done_hit);

    // Classify the incoming address phase into its data-phase state.
    always_comb begin
        addr_target = ST_DATA;
        if (a_off == 4'h2 || a_off == 4'h3) begin
            addr_target = ST_ERR1;
        end else if (a_off[3:2] == 2'b11) begin
            if (bus.HWRITE)  addr_target = ST_ERR1;
            else if (busy_d) addr_target = ST_WAIT;
        end else if (a_off[3:2] != 2'b00 && bus.HWRITE && busy_d) begin
            addr_target = ST_ERR1;
        end
    end

    // Bus FSM next state and response.
    always_comb begin
        next_state = state;
        hresp      = 1'b0;
        case (state)
            ST_IDLE, ST_DATA: next_state = accept ? addr_target : ST_IDLE;
            ST_WAIT: begin
                if (done_hit)                   next_state = ST_DATA;
                else if (wait_cnt == WAIT_LAST) next_state = ST_ERR1;
            end
            ST_ERR1: begin
                hresp      = 1'b1;
                next_state = ST_ERR2;
            end
            ST_ERR2: begin
                hresp      = 1'b1;
                next_state = accept ? addr_target : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Bus FSM state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Latch the accepted address phase for its data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            off_q <= '0;
            wr_q  <= 1'b0;
        end else if (accept) begin
            off_q <= a_off;
            wr_q  <= bus.HWRITE;
        end
    end

    // Count stall cycles of a CT read waiting on the core.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)              wait_cnt <= '0;
        else if (state != ST_WAIT) wait_cnt <= '0;
        else                       wait_cnt <= wait_cnt + CW'(1);
    end

    // Register file, START/BUSY/DONE/OVERRUN control and CT capture.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int unsigned i = 0; i < 4; i++) begin
                key[i] <= '0;
                pt[i]  <= '0;
                ct[i]  <= '0;
            end
            irq_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= start_fire;
            busy    <= busy_d;
            if (ctrl_wr) irq_en <= wdata[1];
            if (done_hit) begin
                for (int unsigned i = 0; i < 4; i++) ct[i] <= aes_ct[32*i +: 32];
                done <= 1'b1;
            end else if (start_fire) begin
                done <= 1'b0;
            end else if (status_wr && wdata[1]) begin
                done <= 1'b0;
            end
            if (overrun_set)                   overrun <= 1'b1;
            else if (status_wr && wdata[2])    overrun <= 1'b0;
            if (wr_en && off_q[3:2] == 2'b01) key[off_q[1:0]] <= wdata;
            if (wr_en && off_q[3:2] == 2'b10) pt[off_q[1:0]]  <= wdata;
        end
    end

    // Level interrupt, registered from DONE and IRQ_EN.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) irq_q <= 1'b0;
        else          irq_q <= done & irq_en;
    end

    // Read mux from the latched offset.
    always_comb begin
        rdata = '0;
        case (off_q[3:2])
            2'b00: begin
                if (off_q[1:0] == 2'b00)      rdata = {30'b0, irq_en, 1'b0};
                else if (off_q[1:0] == 2'b01) rdata = {29'b0, overrun, done, busy};
            end
            2'b01:   rdata = key[off_q[1:0]];
            2'b10:   rdata = pt[off_q[1:0]];
            default: rdata = ct[off_q[1:0]];
        endcase
    end

    assign bus.HREADYOUT = hready_out;
    assign bus.HRESP     = hresp;
    assign bus.HRDATA    = (state == ST_DATA && !wr_q) ? rdata : '0;

    assign aes_key   = {key[3], key[2], key[1], key[0]};
    assign aes_pt    = {pt[3], pt[2], pt[1], pt[0]};
    assign aes_start = start_q;
    assign irq       = irq_q;

endmodule
